flag_stack_register: RTL

Parametrised processor flag register with a hardware save/restore stack. Holds the current FLAG_W-bit flag word (bit-maskable writes from the execute stage) and lets control logic push the flags on call/interrupt entry and pop them on return, all in one clock domain. Reports stack occupancy plus sticky overflow/underflow status to the exception logic.

---
 rtl/flag_stack_register.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/flag_stack_register.sv
// Flag register with a LIFO save/restore stack, maskable writes and sticky overflow/underflow status.
// Optional FLAG_STACK_WRAP_EN: a push while full drops the oldest entry instead of being ignored.
module flag_stack_register #(
  parameter int                FLAG_W  = 6,
  parameter int                DEPTH   = 4,
  parameter logic [FLAG_W-1:0] RST_VAL = {FLAG_W{1'b0}}
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [FLAG_W-1:0]          data_i,
  input  logic [FLAG_W-1:0]          wmask_i,
  input  logic                       write,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clr_err_i,
  output logic [FLAG_W-1:0]          data_o,
  output logic [$clog2(DEPTH+1)-1:0] depth_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic                       ovf_o,
  output logic                       udf_o
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);
  localparam logic [DW-1:0] DEPTH_ONE = DW'(1);
  localparam logic [DW-1:0] DEPTH_ZERO = DW'(0);
  localparam logic [PW-1:0] PTR_MAX  = PW'(DEPTH - 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] PTR_ZERO = PW'(0);

  logic [FLAG_W-1:0] stack_q [DEPTH];
  logic [FLAG_W-1:0] data_q, data_d;
  logic [DW-1:0]     depth_q, depth_d;
  logic [PW-1:0]     ptr_q, ptr_d;  // next free slot; top lives one below it
  logic              empty_q, full_q, ovf_q, ovf_d, udf_q, udf_d;

  logic [PW-1:0]     ptr_inc_s, ptr_dec_s, waddr_s;
  logic [FLAG_W-1:0] top_s, base_s;
  logic              we_s, do_push_s, do_pop_s, do_xchg_s, ovf_ev_s, udf_ev_s;

  assign ptr_inc_s = (ptr_q == PTR_MAX) ? PTR_ZERO : ptr_q + PTR_ONE;
  assign ptr_dec_s = (ptr_q == PTR_ZERO) ? PTR_MAX : ptr_q - PTR_ONE;
  assign top_s     = stack_q[ptr_dec_s];

  // A push+pop on an empty stack degenerates into a plain push.
  assign do_xchg_s = push & pop & ~empty_q;
  assign do_push_s = push & ~do_xchg_s;
  assign do_pop_s  = pop & ~push & ~empty_q;
  assign udf_ev_s  = pop & ~push & empty_q;
  assign ovf_ev_s  = push & ~pop & full_q;

  // Stack pointer/depth update and selection of the base flag value
  always_comb begin
    base_s  = data_q;
    depth_d = depth_q;
    ptr_d   = ptr_q;
    we_s    = 1'b0;
    waddr_s = ptr_q;
    if (do_xchg_s) begin
      base_s  = top_s;
      we_s    = 1'b1;
      waddr_s = ptr_dec_s;
    end else if (do_pop_s) begin
      base_s  = top_s;
      depth_d = depth_q - DEPTH_ONE;
      ptr_d   = ptr_dec_s;
    end else if (do_push_s) begin
      if (!full_q) begin
        we_s    = 1'b1;
        ptr_d   = ptr_inc_s;
        depth_d = depth_q + DEPTH_ONE;
      end else begin
`ifdef FLAG_STACK_WRAP_EN
        // Circular buffer: when full, the free slot pointer sits on the oldest entry.
        we_s  = 1'b1;
        ptr_d = ptr_inc_s;
`else
        we_s  = 1'b0;
        ptr_d = ptr_q;
`endif
      end
    end else begin
      base_s = data_q;
    end
  end

  // Masked write on top of the base value, and sticky error flags
  always_comb begin
    data_d = base_s;
    ovf_d  = ovf_q;
    udf_d  = udf_q;
    if (write) begin
      data_d = (base_s & ~wmask_i) | (data_i & wmask_i);
    end else begin
      data_d = base_s;
    end
    if (ovf_ev_s) begin
      ovf_d = 1'b1;
    end else if (clr_err_i) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    if (udf_ev_s) begin
      udf_d = 1'b1;
    end else if (clr_err_i) begin
      udf_d = 1'b0;
    end else begin
      udf_d = udf_q;
    end
  end

  // Control and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= RST_VAL;
      depth_q <= DEPTH_ZERO;
      ptr_q   <= PTR_ZERO;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      depth_q <= depth_d;
      ptr_q   <= ptr_d;
      empty_q <= (depth_d == DEPTH_ZERO);
      full_q  <= (depth_d == DEPTH_MAX);
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Stack storage is deliberately left unreset
  always_ff @(posedge clk) begin
    if (we_s && !rst) begin
      stack_q[waddr_s] <= data_q;
    end
  end

  assign data_o  = data_q;
  assign depth_o = depth_q;
  assign empty_o = empty_q;
  assign full_o  = full_q;
  assign ovf_o   = ovf_q;
  assign udf_o   = udf_q;

endmodule
